// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// Optional macro OVF_FLAG_EN adds the signed-overflow flag.
interface serial_add_sub_if;
  localparam int unsigned W = 4;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout
`ifdef OVF_FLAG_EN
    , input ovf
`endif
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout
`ifdef OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial 4-bit two's-complement adder/subtractor, one bit per cycle, LSB first.
// Subtraction is A + ~B + 1 (carry preloaded with sub).
// Optional macro OVF_FLAG_EN adds a registered signed-overflow flag.
module serial_add_sub (
  input logic            clk,
  input logic            rst,
  serial_add_sub_if.slave bus
);
  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
`ifdef OVF_FLAG_EN
  logic          ovf_q, ovf_d;
`endif

  logic sum_c;
  logic carry_out_c;

  // Full adder on the current LSBs
  always_comb begin
    sum_c       = a_q[0] ^ b_q[0] ^ carry_q;
    carry_out_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_c, res_q[W-1:1]};
        carry_d = carry_out_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cout_d  = carry_out_c;
`ifdef OVF_FLAG_EN
          // carry_q here is the carry into the sign bit
          ovf_d   = carry_q ^ carry_out_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
`ifdef OVF_FLAG_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, asynchronous, active-high.
- REQ-003: in_valid  input  1  operand set (a, b, sub) is valid this cycle.
- REQ-004: in_ready  output  1  block accepts an operand set this cycle.
- REQ-005: a  input  4  minuend/augend, two's complement.
- REQ-006: b  input  4  subtrahend/addend, two's complement.
- REQ-007: sub  input  1  1 = compute a-b, 0 = compute a+b.
- REQ-008: out_valid  output  1  result, cout (and ovf) are valid.
- REQ-009: out_ready  input  1  consumer takes the result this cycle.
- REQ-010: result  output  4  (a ± b) mod 16.
- REQ-011: cout  output  1  carry out of bit 3 of the serial addition.
- REQ-012: ovf  output  1  signed overflow; present only with OVF_FLAG_EN (REQ-027).

Function
- REQ-013: The FSM SHALL have exactly three states: IDLE, RUN, DONE.
- REQ-014: in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
- REQ-015: Accept handshake (in_valid & in_ready at edge E) SHALL latch a, b and sub, clear the bit counter, and move IDLE->RUN; a, b and sub are ignored at all other times.
- REQ-016: On accept, the carry flop SHALL load sub, and the B operand register SHALL load b when sub=0 or ~b when sub=1 (two's-complement subtraction as A + ~B + 1).
- REQ-017: RUN SHALL process one bit per cycle, LSB first: sum = A[i] ^ B'[i] ^ c; carry = majority(A[i], B'[i], c); sum bit shifts into the result register.
- REQ-018: After four RUN cycles (edges E+1..E+4), the FSM SHALL move RUN->DONE, so out_valid is 1 starting with the cycle after edge E+4 (fixed 4-cycle latency).
- REQ-019: cout SHALL equal the carry out of bit 3; for sub=1, cout=1 means no borrow (a >= b unsigned).
- REQ-020: In DONE, result, cout and ovf SHALL remain stable until out_valid & out_ready, then the FSM SHALL move DONE->IDLE; in_ready is 1 on the next cycle (one operation per ≥6 cycles).
- REQ-021: Subtracting b=4'b1000 SHALL use the same datapath without special casing (0-(-8) -> 4'b1000).
- REQ-022: in_valid while not in IDLE SHALL have no effect; the upstream holds the operands until in_ready.

Reset
- REQ-023: rst=1 SHALL force, without waiting for a clock edge: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, carry=0, bit counter=0.
- REQ-024: rst asserted during RUN or DONE SHALL abort the operation; the pending result SHALL be lost and never presented.
- REQ-025: On the first edge after rst deasserts, the block SHALL accept a handshake if in_valid=1.

Configuration
- REQ-026: Macro OVF_FLAG_EN SHALL be the only compile-time option.
- REQ-027: With OVF_FLAG_EN defined: port ovf exists and equals (carry into bit 3) XOR (carry out of bit 3), registered with result. Without it: port ovf and its logic are absent; all other behaviour is identical.

Verification
- REQ-028: a=0011, b=0010, sub=0 -> result=0101, cout=0, ovf=0, out_valid first high 5 cycles after the accept cycle.
- REQ-029: a=0011, b=0101, sub=1 -> result=1110, cout=0, ovf=0; a=0101, b=0101, sub=1 -> result=0000, cout=1, ovf=0.
- REQ-030: a=0111, b=0001, sub=0 -> result=1000, cout=0, ovf=1 (OVF_FLAG_EN); a=0000, b=1000, sub=1 -> result=1000, cout=0, ovf=1.
- REQ-031: out_ready held 0 for 3 cycles in DONE -> result/cout/ovf unchanged, in_ready=0 and new in_valid ignored throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
- REQ-032: rst pulsed mid-edge during the 2nd RUN cycle -> out_valid=0, result=0 immediately; no result is delivered for that operand set; a new operation after reset completes correctly.
- REQ-033: Build without OVF_FLAG_EN and rerun REQ-028..REQ-030 -> identical result/cout and handshake timing; port ovf absent.
